// File: rtl/flash_adc_pkg.sv
// Shared constants, types and helpers for the flash ADC thermometer encoder.
package flash_adc_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic {ACC, EMIT} avg_state_e;

  function automatic int unsigned therm_w(input int unsigned n);
    return (2 ** n) - 1;
  endfunction

endpackage

// File: rtl/therm_bubble_fix.sv
// Combinational 3-input majority bubble correction for a thermometer word.
module therm_bubble_fix #(
  parameter int unsigned M = 7
) (
  input  logic [M-1:0] i_therm,
  output logic [M-1:0] o_fixed,
  output logic         o_corr
);

  // Padded word: bit below the lowest threshold reads 1, bit above the top reads 0.
  logic [M+1:0] w_pad;
  assign w_pad = {1'b0, i_therm, 1'b1};

  always_comb begin
    o_fixed = '0;
    for (int i = 0; i < int'(M); i++) begin
      o_fixed[i] = (w_pad[i] & w_pad[i+1]) | (w_pad[i] & w_pad[i+2]) |
                   (w_pad[i+1] & w_pad[i+2]);
    end
  end

  assign o_corr = (o_fixed != i_therm);

endmodule

// File: rtl/flash_adc_encoder.sv
// Registered thermometer-to-binary encoder with valid/ready output and bubble repair.
// Optional sample averaging is enabled by defining FLASH_ADC_AVG_EN.
module flash_adc_encoder
  import flash_adc_pkg::*;
#(
  parameter int unsigned NBITS    = 3,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_en,
  input  logic [therm_w(NBITS)-1:0]     therm,
  output logic [NBITS-1:0]              code,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic                          bubble_err,
  output logic                          overflow,
  output logic [ERR_CNT_W-1:0]          err_count
);

  localparam int unsigned M = therm_w(NBITS);

  if (NBITS < 2 || NBITS > 6) begin : g_bad_nbits
    $error("NBITS out of range");
  end
  if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg
    $error("AVG_LOG2 out of range");
  end

  logic [M-1:0]     r_cap;
  logic             r_cap_v;
  logic [M-1:0]     w_c;
  logic             w_corr;
  logic [NBITS-1:0] w_res;
  logic             w_run;
  logic             w_new_v;
  logic [NBITS-1:0] w_new_code;

  logic [NBITS-1:0]     r_code;
  logic                 r_code_valid;
  logic                 r_bubble_err;
  logic                 r_overflow;
  logic [ERR_CNT_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap   <= '0;
      r_cap_v <= 1'b0;
    end else begin
      r_cap_v <= sample_en;
      if (sample_en) r_cap <= therm;
    end
  end

  therm_bubble_fix #(
    .M (M)
  ) u_fix (
    .i_therm (r_cap),
    .o_fixed (w_c),
    .o_corr  (w_corr)
  );

  // Count the leading run of ones; anything above the first zero is ignored.
  always_comb begin
    w_res = '0;
    w_run = 1'b1;
    for (int i = 0; i < int'(M); i++) begin
      if (w_run && w_c[i]) w_res = w_res + 1'b1;
      else                 w_run = 1'b0;
    end
  end

`ifdef FLASH_ADC_AVG_EN
  localparam int unsigned SW = NBITS + AVG_LOG2;
  localparam logic [AVG_LOG2:0] AVG_N = {1'b1, {AVG_LOG2{1'b0}}};

  avg_state_e        r_state, w_state_d;
  logic [SW-1:0]     r_sum, w_sum_d;
  logic [AVG_LOG2:0] r_cnt, w_cnt_d;
  logic [SW-1:0]     w_res_ext;

  assign w_res_ext = {{AVG_LOG2{1'b0}}, w_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_sum   <= w_sum_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_sum_d    = r_sum;
    w_cnt_d    = r_cnt;
    w_new_v    = 1'b0;
    w_new_code = r_sum[SW-1:AVG_LOG2];
    unique case (r_state)
      ACC: begin
        if (r_cap_v) begin
          w_sum_d = r_sum + w_res_ext;
          w_cnt_d = r_cnt + 1'b1;
          if (w_cnt_d == AVG_N) w_state_d = EMIT;
        end
      end
      EMIT: begin
        // Restart with the result arriving this cycle so no sample is lost.
        w_new_v   = 1'b1;
        w_sum_d   = r_cap_v ? w_res_ext : '0;
        w_cnt_d   = r_cap_v ? {{AVG_LOG2{1'b0}}, 1'b1} : '0;
        w_state_d = ACC;
      end
      default: w_state_d = ACC;
    endcase
  end
`else
  assign w_new_v    = r_cap_v;
  assign w_new_code = w_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_bubble_err <= 1'b0;
      r_overflow   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_bubble_err <= r_cap_v & w_corr;
      r_overflow   <= 1'b0;
      if (r_cap_v && w_corr && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
      if (w_new_v) begin
        if (!r_code_valid || code_ready) begin
          r_code       <= w_new_code;
          r_code_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_code_valid && code_ready) begin
        r_code_valid <= 1'b0;
      end
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign bubble_err = r_bubble_err;
  assign overflow   = r_overflow;
  assign err_count  = r_err_count;

endmodule

// File: doc/flash_adc_encoder.md
Name: flash_adc_encoder

Overview:
Parametrised, registered thermometer-to-binary encoder for an NBITS flash ADC front end.
- Captures the 2^NBITS-1 comparator outputs on a sample strobe.
- Repairs single-bit "bubbles" with 3-input majority voting, then encodes the result to binary.
- Presents the code on a valid/ready output with backpressure and error reporting.
- Sits between the comparator bank and the downstream sample consumer (DSP or FIFO).

Parameters:
- NBITS, 3, output code width; thermometer width M = 2^NBITS-1 (legal range 2..6).
- AVG_LOG2, 2, log2 of the number of samples averaged; used only when FLASH_ADC_AVG_EN is defined (legal range 1..4).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sample_en  in  1  capture strobe; therm is sampled on a clk edge where sample_en=1
- therm  in  M  comparator outputs; bit 0 is the lowest threshold
- code  out  NBITS  encoded result; held stable while code_valid=1 and code_ready=0
- code_valid  out  1  code holds a result not yet accepted
- code_ready  in  1  consumer accepts on a clk edge where code_valid=1 and code_ready=1
- bubble_err  out  1  one-cycle pulse: the result just produced needed correction
- overflow  out  1  one-cycle pulse: a new result was dropped because of backpressure
- err_count  out  8  saturating count of corrected samples

Behaviour:
- Reset (rst=1 at a clk edge): code=0, code_valid=0, bubble_err=0, overflow=0, err_count=0. Capture valid and accumulator are cleared. All in-flight samples are discarded; there is no partial output after reset.
- Stage 1 (capture): on an edge with sample_en=1, cap<=therm and cap_v<=1; otherwise cap_v<=0. A strobe every cycle is legal.
- Stage 2 (correct + encode), combinational from cap:
  - Padded neighbours: t[-1]=1, t[M]=0.
  - Corrected bit c[i] = majority(t[i-1], t[i], t[i+1]), computed from the raw captured bits.
  - Result r = number of consecutive ones in c starting at bit 0. Range 0..M; it fits in NBITS.
  - If c is still not a valid thermometer word, bits above the first zero are ignored.
  - Corrected flag corr = (c != cap).
- Result register: when cap_v=1, a result is produced on the next edge. bubble_err=corr for that single cycle, and err_count increments if corr=1, saturating at 255.
- Latency without averaging: sample_en=1 in cycle k gives code_valid=1 from cycle k+2 (after two edges).
- Output handshake, evaluated on the edge where a new result arrives:
  - If code_valid=0, or code_ready=1: load the result and set code_valid=1. A simultaneous accept and load keeps code_valid=1 with the new code.
  - If code_valid=1 and code_ready=0: keep the old code, drop the new one, and pulse overflow for one cycle. bubble_err and err_count still reflect the dropped sample.
- On an accept edge with no new result: code_valid<=0. code retains its last value.
- code_ready is ignored while code_valid=0.

Optional Feature:
Macro FLASH_ADC_AVG_EN.
- Defined:
  - Stage-2 results feed an accumulator of width NBITS+AVG_LOG2 and a sample counter. The FSM has two states, ACC and EMIT.
  - In ACC, each result is added. When the count reaches 2^AVG_LOG2, the FSM moves to EMIT.
  - In EMIT, the output value is (sum >> AVG_LOG2), truncated. This value goes through the same handshake and overflow rules.
  - In EMIT, the accumulator is cleared and loaded with the current-cycle result if one is present, and the FSM returns to ACC. No sample is lost at the block boundary.
  - bubble_err and err_count remain per-sample.
- Not defined: every stage-2 result goes directly to the output, and no accumulator logic is generated.

Decomposition:
- Package flash_adc_pkg holds:
  - function therm_w(n) = 2**n-1
  - localparam ERR_CNT_W=8
  - the averaging FSM state enum {ACC, EMIT}
- Sub-module therm_bubble_fix (parameter M): purely combinational majority correction that outputs c and corr. Encoding, handshake and averaging stay in the top level.

Test Plan (NBITS=3, M=7):
- Clean code: sample_en=1, therm=7'b0000111, code_ready=1 → two edges later code=3, code_valid=1 for 1 cycle, bubble_err=0.
- Bubble: therm=7'b0001011 → code=3, bubble_err pulses once, err_count=1. Then therm=7'b1111111 → code=7; therm=7'b0000000 → code=0.
- Backpressure: code_ready=0, samples 7'b0000001 then 7'b0011111 → code=1 held, overflow pulses once, code never shows 5. Raise code_ready → code_valid drops the next cycle.
- Simultaneous events: code_valid=1 with code_ready=1 on the same edge a new result (code 6) arrives → code=6, code_valid stays 1, overflow=0.
- Saturation and reset: 300 bubbled samples → err_count=255 and holds. Assert rst mid-stream with a sample in stage 1 → all outputs 0 next cycle, and no stale code appears afterwards.
- Averaging (macro defined, AVG_LOG2=2): codes 3,4,4,5 → a single output of 4. Codes 7,7,7,6 → 6 (27>>2, truncated). A 5th sample arriving in the EMIT cycle is counted in the next average.
